// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp sequencer: ramps duty up to a target, dwells, ramps down.
// Duty only moves on frame boundaries so the PWM never glitches mid-frame.
module pwm_ramp_ctrl #(
    parameter int DW       = 8,
    parameter int MAXCOUNT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          ABORT,
    input  logic [DW-1:0] TARGET,
    input  logic [DW-1:0] STEP,
    input  logic [DW-1:0] HOLD_FRAMES,
    output logic [DW-1:0] DUTY,
    output logic          FRAME_END,
    output logic          BUSY,
    output logic          DONE
);

    localparam int CW = (MAXCOUNT > 0) ? $clog2(MAXCOUNT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [DW-1:0] hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [DW-1:0] step_q, step_d;
    logic [DW-1:0] hold_cfg_q, hold_cfg_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          done_q, done_d;
    logic          fe;
    logic [DW:0]   up_sum;

    assign fe = (frame_cnt_q == CW'(MAXCOUNT));

    always_comb begin
        frame_cnt_d = fe ? '0 : frame_cnt_q + 1'b1;
    end

    // One extra bit so a large step cannot wrap past the target
    assign up_sum = {1'b0, duty_q} + {1'b0, step_q};

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        hold_cfg_d = hold_cfg_q;
        duty_d     = duty_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    tgt_d      = TARGET;
                    step_d     = (STEP == '0) ? DW'(1) : STEP;
                    hold_cfg_d = HOLD_FRAMES;
                    state_d    = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (ABORT) begin
                    state_d = RAMP_DOWN;
                end else if (fe) begin
                    if (duty_q == tgt_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = hold_cfg_q;
                    end else if (up_sum > {1'b0, tgt_q}) begin
                        duty_d = tgt_q;
                    end else begin
                        duty_d = up_sum[DW-1:0];
                    end
                end
            end
            HOLD: begin
                if (ABORT) begin
                    state_d = RAMP_DOWN;
                end else if (fe) begin
                    if (hold_cnt_q == '0) begin
                        state_d = RAMP_DOWN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - 1'b1;
                    end
                end
            end
            RAMP_DOWN: begin
                if (fe) begin
                    if (duty_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (duty_q > step_q) begin
                        duty_d = duty_q - step_q;
                    end else begin
                        duty_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            tgt_q       <= '0;
            step_q      <= '0;
            hold_cfg_q  <= '0;
            duty_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            tgt_q       <= tgt_d;
            step_q      <= step_d;
            hold_cfg_q  <= hold_cfg_d;
            duty_q      <= duty_d;
            done_q      <= done_d;
        end
    end

    assign DUTY      = duty_q;
    assign FRAME_END = RST_N && fe;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;

endmodule
